// File: rtl/matmul_systolic_nxn.sv
// Output-stationary N x N systolic matrix multiplier (C = A*B, signed), skewing, drain and row sequencing included.
// Build option: define MATMUL_RELU_EN to clamp negative results to zero on out_row_flat.
module matmul_systolic_nxn #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int ACC_W = 2*W + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_a_flat,
    input  logic [N*W-1:0]       in_b_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*ACC_W-1:0]   out_row_flat,
    output logic [$clog2(N)-1:0] out_row_idx,
    output logic                 out_last,
    output logic                 busy
);
    localparam int RW = $clog2(N);
    localparam int DW = $clog2(2*N);
    localparam int PW = 2*W;
    localparam logic [RW-1:0] LAST_IDX  = RW'(N-1);
    localparam logic [DW-1:0] DRAIN_LEN = DW'(2*N-2);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} stateT;
    stateT state, stateNext;

    logic [RW-1:0] beatCnt;
    logic [DW-1:0] drainCnt;
    logic          accept, lastBeat, shiftEn, clearAcc, rowDone;

    logic signed [W-1:0]     skewA [N];
    logic signed [W-1:0]     skewB [N];
    logic signed [W-1:0]     aIn   [N][N];
    logic signed [W-1:0]     bIn   [N][N];
    logic signed [W-1:0]     aPipe [N][N-1];
    logic signed [W-1:0]     bPipe [N-1][N];
    logic signed [PW-1:0]    prod  [N][N];
    logic signed [ACC_W-1:0] acc   [N][N];
    logic [RW-1:0]           loadIdx;
    logic [N*ACC_W-1:0]      rowData;

    assign accept   = in_valid && in_ready;
    assign lastBeat = accept && (beatCnt == LAST_IDX);
    assign clearAcc = accept && (state == IDLE);
    assign shiftEn  = accept || (state == LOAD) || (state == DRAIN);
    assign rowDone  = out_valid && out_ready && out_last;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // NOTE: default assignment before the case keeps this block latch-free.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (accept)          stateNext = LOAD;
            LOAD:    if (lastBeat)        stateNext = DRAIN;
            DRAIN:   if (drainCnt == '0)  stateNext = OUTPUT;
            OUTPUT:  if (rowDone)         stateNext = IDLE;
            default:                      stateNext = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) || (state == LOAD);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beatCnt  <= '0;
            drainCnt <= '0;
        end else begin
            if (accept) beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
            if (lastBeat)
                drainCnt <= DRAIN_LEN;
            else if (state == DRAIN && drainCnt != '0)
                drainCnt <= drainCnt - 1'b1;
        end
    end

    // Lane i is delayed i cycles; idle/gap cycles inject zeros so the array can keep shifting.
    for (genvar i = 0; i < N; i++) begin : gSkew
        logic signed [W-1:0] injA, injB;
        assign injA = accept ? $signed(in_a_flat[(N-1-i)*W +: W]) : '0;
        assign injB = accept ? $signed(in_b_flat[(N-1-i)*W +: W]) : '0;
        if (i == 0) begin : gDirect
            assign skewA[i] = injA;
            assign skewB[i] = injB;
        end else begin : gDelay
            logic signed [W-1:0] srA [i];
            logic signed [W-1:0] srB [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) begin
                        srA[s] <= '0;
                        srB[s] <= '0;
                    end
                end else if (shiftEn) begin
                    srA[0] <= injA;
                    srB[0] <= injB;
                    for (int s = 1; s < i; s++) begin
                        srA[s] <= srA[s-1];
                        srB[s] <= srB[s-1];
                    end
                end
            end
            assign skewA[i] = srA[i-1];
            assign skewB[i] = srB[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            aIn[i][0] = skewA[i];
            for (int j = 1; j < N; j++) aIn[i][j] = aPipe[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            bIn[0][j] = skewB[j];
            for (int i = 1; i < N; i++) bIn[i][j] = bPipe[i-1][j];
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                prod[i][j] = PW'(aIn[i][j]) * PW'(bIn[i][j]);
    end

    // NOTE: the accumulator array is reset explicitly so an aborted run leaves no partial sums behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) acc[i][j] <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N-1; j++) aPipe[i][j] <= '0;
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++) bPipe[i][j] <= '0;
        end else if (shiftEn) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] <= (clearAcc ? '0 : acc[i][j]) + ACC_W'(prod[i][j]);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N-1; j++) aPipe[i][j] <= aIn[i][j];
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++) bPipe[i][j] <= bIn[i][j];
        end
    end

    always_comb begin
        loadIdx = out_valid ? out_row_idx + 1'b1 : '0;
        rowData = '0;
        for (int j = 0; j < N; j++) begin
`ifdef MATMUL_RELU_EN
            rowData[(N-1-j)*ACC_W +: ACC_W] = acc[loadIdx][j][ACC_W-1] ? '0 : acc[loadIdx][j];
`else
            rowData[(N-1-j)*ACC_W +: ACC_W] = acc[loadIdx][j];
`endif
        end
    end

    // Row register reloads on the first OUTPUT cycle and on every handshake, holding otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_row_flat <= '0;
            out_row_idx  <= '0;
            out_last     <= 1'b0;
        end else if (state == OUTPUT && (!out_valid || out_ready)) begin
            if (out_valid && out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_valid    <= 1'b1;
                out_row_idx  <= loadIdx;
                out_last     <= (loadIdx == LAST_IDX);
                out_row_flat <= rowData;
            end
        end
    end

endmodule

// File: tb/tb_matmul_systolic_nxn.sv
// Bench for matmul_systolic_nxn: N=4/W=32 instance checked against a plain matrix-product model,
// plus an N=2/W=8 instance with fixed operands. Honours MATMUL_RELU_EN in its expectations.
module tb_matmul_systolic_nxn;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int AW  = 2*W + $clog2(N);
    localparam int N2  = 2;
    localparam int W2  = 8;
    localparam int AW2 = 2*W2 + $clog2(N2);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 inValid, inReady, outValid, outReady, outLast, busy;
    logic [N*W-1:0]       inA, inB;
    logic [N*AW-1:0]      outRow;
    logic [$clog2(N)-1:0] outRowIdx;

    logic                  inValid2, inReady2, outValid2, outReady2, outLast2, busy2;
    logic [N2*W2-1:0]      inA2, inB2;
    logic [N2*AW2-1:0]     outRow2;
    logic [$clog2(N2)-1:0] outRowIdx2;

    int nChecks = 0;
    int nFail   = 0;
    int cycle   = 0;

    logic signed [W-1:0] matA [N][N];
    logic signed [W-1:0] matB [N][N];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    matmul_systolic_nxn #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady),
        .in_a_flat(inA), .in_b_flat(inB),
        .out_valid(outValid), .out_ready(outReady),
        .out_row_flat(outRow), .out_row_idx(outRowIdx),
        .out_last(outLast), .busy(busy)
    );

    matmul_systolic_nxn #(.N(N2), .W(W2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(inValid2), .in_ready(inReady2),
        .in_a_flat(inA2), .in_b_flat(inB2),
        .out_valid(outValid2), .out_ready(outReady2),
        .out_row_flat(outRow2), .out_row_idx(outRowIdx2),
        .out_last(outLast2), .busy(busy2)
    );

    task automatic check(input string tag, input logic signed [127:0] obs, input logic signed [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [127:0] relu(input logic signed [127:0] v);
`ifdef MATMUL_RELU_EN
        return (v < 0) ? 128'sd0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: plain sum of products at 128-bit precision.
    function automatic logic signed [127:0] expC(input int i, input int j);
        logic signed [127:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s += 128'(matA[i][k]) * 128'(matB[k][j]);
        return relu(s);
    endfunction

    function automatic logic signed [127:0] lane(input int j);
        logic signed [AW-1:0] v;
        v = outRow[(N-1-j)*AW +: AW];
        return 128'(v);
    endfunction

    task automatic sendBeats(input int gap, output int lastEdge);
        int budget;
        int g;
        lastEdge = 0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                inA[(N-1-i)*W +: W] = matA[i][k];
                inB[(N-1-i)*W +: W] = matB[k][i];
            end
            inValid = 1'b1;
            budget = 40;
            while (!inReady && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (!inReady) check("beat wait in_ready", 128'(inReady), 128'(1));
            @(negedge clk);
            lastEdge = cycle;
            inValid = 1'b0;
            inA = {$urandom(), $urandom(), $urandom(), $urandom()};
            inB = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (k < N-1) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) @(negedge clk);
            end
        end
    endtask

    task automatic collectRows(input string tag, input int lastEdge, input int stallRow, input int stallCycles);
        int rows = 0;
        int stalls = 0;
        int budget = 200;
        bit seen = 1'b0;
        outReady = 1'b1;
        while (rows < N && budget > 0) begin
            @(negedge clk);
            budget--;
            if (outValid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check({tag, " latency"}, 128'(cycle - lastEdge), 128'(2*N));
                    check({tag, " in_ready in OUTPUT"}, 128'(inReady), 128'(0));
                end
                check($sformatf("%s r%0d idx", tag, rows), 128'(outRowIdx), 128'(rows));
                check($sformatf("%s r%0d last", tag, rows), 128'(outLast), 128'(rows == N-1));
                for (int j = 0; j < N; j++)
                    check($sformatf("%s r%0d c%0d", tag, rows, j), lane(j), expC(rows, j));
                if (rows == stallRow && stalls < stallCycles) begin
                    outReady = 1'b0;
                    stalls++;
                end else begin
                    outReady = 1'b1;
                    rows++;
                end
            end
        end
        check({tag, " rows delivered"}, 128'(rows), 128'(N));
        @(negedge clk);
        check({tag, " out_valid after last"}, 128'(outValid), 128'(0));
        check({tag, " busy after last"}, 128'(busy), 128'(0));
        check({tag, " in_ready after last"}, 128'(inReady), 128'(1));
    endtask

    task automatic runOp(input string tag, input int gap, input int stallRow, input int stallCycles);
        int e;
        sendBeats(gap, e);
        check({tag, " in_ready drops"}, 128'(inReady), 128'(0));
        check({tag, " busy in DRAIN"}, 128'(busy), 128'(1));
        collectRows(tag, e, stallRow, stallCycles);
    endtask

    task automatic setIdentity();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                matA[i][j] = W'(i*N + j + 1);
                matB[i][j] = (i == j) ? W'(1) : W'(0);
            end
    endtask

    task automatic setConst(input int a, input int b);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                matA[i][j] = W'(a);
                matB[i][j] = W'(b);
            end
    endtask

    initial begin
        int e;
        int sawValid;
        int wait2;
        logic signed [AW2-1:0] l0, l1;

        rst = 1'b1;
        inValid = 1'b0; inA = '0; inB = '0; outReady = 1'b1;
        inValid2 = 1'b0; inA2 = '0; inB2 = '0; outReady2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset out_valid", 128'(outValid), 128'(0));
        check("reset out_row_flat", 128'(|outRow), 128'(0));
        check("reset out_row_idx", 128'(outRowIdx), 128'(0));
        check("reset out_last", 128'(outLast), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset in_ready", 128'(inReady), 128'(1));

        setIdentity();
        runOp("identity", 0, -1, 0);

        setConst(1, 1);
        runOp("ones_gap", 2, -1, 0);

        setIdentity();
        runOp("backpressure", 0, 1, 3);

        setConst(-3, 7);
        runOp("signed", 0, -1, 0);

        // Abort two cycles into DRAIN, then confirm nothing leaks out and a fresh run is clean.
        setIdentity();
        sendBeats(0, e);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset out_valid", 128'(outValid), 128'(0));
        check("mid reset busy", 128'(busy), 128'(0));
        check("mid reset in_ready", 128'(inReady), 128'(1));
        sawValid = 0;
        repeat (3*N) begin
            @(negedge clk);
            if (outValid) sawValid++;
        end
        check("mid reset no rows", 128'(sawValid), 128'(0));
        runOp("after_reset", 0, -1, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    matA[i][j] = (r == 0) ? 32'h8000_0000 : $urandom();
                    matB[i][j] = (r == 0) ? 32'h8000_0000 : $urandom();
                end
            runOp($sformatf("random%0d", r), -1, int'($urandom_range(0, N-1)), int'($urandom_range(0, 3)));
        end

        // N=2, W=8: A=[[127,-128],[1,1]], B=[[127,0],[-128,1]].
        inA2 = {8'd127, 8'd1};
        inB2 = {8'd127, 8'd0};
        inValid2 = 1'b1;
        check("n2 in_ready beat0", 128'(inReady2), 128'(1));
        @(negedge clk);
        inA2 = {8'h80, 8'd1};
        inB2 = {8'h80, 8'd1};
        check("n2 in_ready beat1", 128'(inReady2), 128'(1));
        @(negedge clk);
        e = cycle;
        inValid2 = 1'b0;
        wait2 = 0;
        while (!outValid2 && wait2 < 20) begin
            @(negedge clk);
            wait2++;
        end
        check("n2 latency", 128'(cycle - e), 128'(4));
        l0 = outRow2[AW2 +: AW2];
        l1 = outRow2[0 +: AW2];
        check("n2 r0 idx", 128'(outRowIdx2), 128'(0));
        check("n2 r0 last", 128'(outLast2), 128'(0));
        check("n2 r0 c0", 128'(l0), relu(128'sd32513));
        check("n2 r0 c1", 128'(l1), relu(-128'sd128));
        @(negedge clk);
        l0 = outRow2[AW2 +: AW2];
        l1 = outRow2[0 +: AW2];
        check("n2 r1 valid", 128'(outValid2), 128'(1));
        check("n2 r1 idx", 128'(outRowIdx2), 128'(1));
        check("n2 r1 last", 128'(outLast2), 128'(1));
        check("n2 r1 c0", 128'(l0), relu(-128'sd1));
        check("n2 r1 c1", 128'(l1), relu(128'sd1));
        @(negedge clk);
        check("n2 out_valid after last", 128'(outValid2), 128'(0));
        check("n2 busy after last", 128'(busy2), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule
